arbiter_puf: RTL and testbench

- Deterministic, synthesizable behavioural model of an N-stage arbiter PUF (Physically Unclonable Function).
- A launch pulse races two signals through a chain of challenge-controlled switch stages, each with fixed per-stage delays.
- An arbiter resolves which path arrives first and drives the 1-bit response.
- Used as the PUF core in the security subsystem and as a golden reference for challenge/response tests.

---
 rtl/arbiter_puf.sv | 97 +++++++++
 tb/tb_arbiter_puf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/arbiter_puf.sv
// Deterministic behavioural model of an N-stage arbiter PUF: a launch races top/bottom
// delay accumulators through challenge-controlled switch stages, and the arbiter picks the earlier arrival.
module arbiter_puf #(
  parameter int                          N_STAGES = 3,
  parameter int                          DLY_W    = 4,
  parameter logic [N_STAGES*DLY_W-1:0]   DLY_A    = 12'h425,
  parameter logic [N_STAGES*DLY_W-1:0]   DLY_B    = 12'h473,
  parameter logic [N_STAGES*DLY_W-1:0]   DLY_C    = 12'h164,
  parameter logic [N_STAGES*DLY_W-1:0]   DLY_D    = 12'h836
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pulse,
  input  logic [N_STAGES-1:0] challenge,
  output logic                response,
  output logic                busy,
  output logic                done
);

  // Wide enough to sum N_STAGES maximum delays without overflow.
  localparam int AW = DLY_W + $clog2(N_STAGES + 1);
  localparam int SW = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DECIDE} state_t;

  state_t              state;
  logic [N_STAGES-1:0] chal_r;
  logic [AW-1:0]       top;
  logic [AW-1:0]       bot;
  logic [SW-1:0]       stage;
  logic                pulse_q;
  logic                launch;
  logic [DLY_W-1:0]    a_i;
  logic [DLY_W-1:0]    b_i;
  logic [DLY_W-1:0]    c_i;
  logic [DLY_W-1:0]    d_i;

  always_comb begin
    launch = pulse & ~pulse_q & (state == IDLE);
    a_i    = DLY_A[int'(stage)*DLY_W +: DLY_W];
    b_i    = DLY_B[int'(stage)*DLY_W +: DLY_W];
    c_i    = DLY_C[int'(stage)*DLY_W +: DLY_W];
    d_i    = DLY_D[int'(stage)*DLY_W +: DLY_W];
  end

  // pulse_q resets high so a pulse already asserted at reset release is not a launch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      chal_r   <= '0;
      top      <= '0;
      bot      <= '0;
      stage    <= '0;
      pulse_q  <= 1'b1;
      response <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      pulse_q <= pulse;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            chal_r <= challenge;
            top    <= '0;
            bot    <= '0;
            stage  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (chal_r[stage]) begin
            top <= bot + AW'(c_i);
            bot <= top + AW'(d_i);
          end else begin
            top <= top + AW'(a_i);
            bot <= bot + AW'(b_i);
          end
          if (stage == SW'(N_STAGES - 1)) begin
            state <= DECIDE;
          end else begin
            stage <= stage + 1'b1;
          end
        end
        DECIDE: begin
          response <= (top < bot);
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbiter_puf.sv
// Directed and randomized checks of arbiter_puf against an arithmetic race model.
module tb_arbiter_puf;

  logic       clk;
  logic       rst_n;
  logic       pulse;
  logic [2:0] challenge;
  logic       response;
  logic       busy;
  logic       done;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Per-stage delays, stage 0 first.
  int unsigned dly_a [3] = '{5, 2, 4};
  int unsigned dly_b [3] = '{3, 7, 4};
  int unsigned dly_c [3] = '{4, 6, 1};
  int unsigned dly_d [3] = '{6, 3, 8};

  arbiter_puf #(
    .N_STAGES (3),
    .DLY_W    (4),
    .DLY_A    (12'h425),
    .DLY_B    (12'h473),
    .DLY_C    (12'h164),
    .DLY_D    (12'h836)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pulse     (pulse),
    .challenge (challenge),
    .response  (response),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic model(input logic [2:0] c);
    int unsigned t = 0;
    int unsigned b = 0;
    int unsigned nt;
    for (int i = 0; i < 3; i++) begin
      if (c[i]) begin
        nt = b + dly_c[i];
        b  = t + dly_d[i];
        t  = nt;
      end else begin
        t = t + dly_a[i];
        b = b + dly_b[i];
      end
    end
    return (t < b);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch one evaluation and check busy/done timing plus the final response.
  task automatic run_eval(input logic [2:0] c, input logic exp, input string tag);
    @(negedge clk);
    challenge = c;
    pulse     = 1'b1;
    @(negedge clk);
    chk({tag, " busy@1"}, 32'(busy), 32'd1);
    chk({tag, " done@1"}, 32'(done), 32'd0);
    pulse     = 1'b0;
    challenge = 3'($urandom);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      chk($sformatf("%s busy@%0d", tag, i), 32'(busy), 32'd1);
      chk($sformatf("%s done@%0d", tag, i), 32'(done), 32'd0);
    end
    @(negedge clk);
    chk({tag, " done"}, 32'(done), 32'd1);
    chk({tag, " busy_end"}, 32'(busy), 32'd0);
    chk({tag, " response"}, 32'(response), 32'(exp));
  endtask

  initial begin
    logic [7:0] sweep_exp;
    logic [2:0] c;
    logic       r;
    int unsigned ndone;
    logic        resp_at_done;

    sweep_exp = 8'b1101_0011; // bit n = expected response for challenge n
    rst_n     = 1'b0;
    pulse     = 1'b1;
    challenge = 3'b000;

    repeat (3) @(negedge clk);
    chk("reset response", 32'(response), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);

    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("no launch busy %0d", i), 32'(busy), 32'd0);
      chk($sformatf("no launch done %0d", i), 32'(done), 32'd0);
    end
    pulse = 1'b0;
    @(negedge clk);

    for (int n = 0; n < 8; n++) begin
      c = 3'(n);
      run_eval(c, sweep_exp[n], $sformatf("sweep %0d", n));
    end

    run_eval(3'b101, 1'b0, "tie 101");

    // Relaunch attempt while busy must be ignored.
    @(negedge clk);
    challenge = 3'b000;
    pulse     = 1'b1;
    ndone        = 0;
    resp_at_done = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        resp_at_done = response;
      end
      if (i == 1) pulse = 1'b0;
      if (i == 2) begin
        pulse     = 1'b1;
        challenge = 3'b011;
      end
      if (i == 3) pulse = 1'b0;
    end
    chk("relaunch done count", 32'(ndone), 32'd1);
    chk("relaunch response", 32'(resp_at_done), 32'd1);

    // Reset mid-run discards the evaluation.
    @(negedge clk);
    challenge = 3'b010;
    pulse     = 1'b1;
    @(negedge clk);
    pulse = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst response", 32'(response), 32'd0);
    chk("midrst busy", 32'(busy), 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_eval(3'b110, 1'b1, "after reset 110");

    // Response hold with no further launches.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("hold response %0d", i), 32'(response), 32'd1);
      chk($sformatf("hold done %0d", i), 32'(done), 32'd0);
    end

    // Randomized challenges with random idle gaps, including back-to-back launches.
    for (int n = 0; n < 24; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      c = 3'($urandom);
      r = model(c);
      run_eval(c, r, $sformatf("rand %0d ch %0d", n, c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
